// File: rtl/dram_ctrl.sv
// Backing-memory controller below the LLC: in-order request queue, fixed-latency word array access,
// read responses over valid/ready. Latency: LATENCY+1 edges from pop to response; backpressure via queue full.
module dram_ctrl #(
  parameter int W         = 64,
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 8,
  parameter int QDEPTH    = 4
) (
  input  logic         clk_in,
  input  logic         rst_N_in,
  input  logic         req_valid_in,
  output logic         req_ready_out,
  input  logic [W-1:0] req_addr_in,
  input  logic [W-1:0] req_value_in,
  input  logic         req_we_in,
  output logic         resp_valid_out,
  input  logic         resp_ready_in,
  output logic [W-1:0] resp_addr_out,
  output logic [W-1:0] resp_value_out
);

  localparam int OFF  = $clog2(W/8);
  localparam int AW   = $clog2(MEM_WORDS);
  localparam int PW   = $clog2(QDEPTH);
  localparam int CNTW = PW + 1;
  localparam int LW   = $clog2(LATENCY + 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(QDEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [CNTW-1:0] count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0]    act_addr_q, act_addr_d, act_data_q, act_data_d;
  logic            act_we_q, act_we_d;
  logic            resp_valid_q, resp_valid_d;
  logic [W-1:0]    resp_addr_q, resp_addr_d, resp_value_q, resp_value_d;

  logic [W-1:0]    q_addr_q [QDEPTH];
  logic [W-1:0]    q_data_q [QDEPTH];
  logic            q_we_q   [QDEPTH];
  // Backing array is not touched by reset; contents survive it.
  logic [W-1:0]    mem_q    [MEM_WORDS] = '{default: '0};

  logic            enq, deq, mem_we;
  logic [AW-1:0]   act_idx;

  assign req_ready_out  = (count_q != FULL);
  assign resp_valid_out = resp_valid_q;
  assign resp_addr_out  = resp_addr_q;
  assign resp_value_out = resp_value_q;
  assign act_idx        = act_addr_q[OFF +: AW];

  always_comb begin
    enq          = req_valid_in && req_ready_out;
    deq          = (state_q == S_IDLE) && (count_q != '0);
    wr_ptr_d     = wr_ptr_q + PW'(enq);
    rd_ptr_d     = rd_ptr_q + PW'(deq);
    count_d      = count_q + CNTW'(enq) - CNTW'(deq);
    state_d      = state_q;
    cnt_d        = cnt_q;
    act_addr_d   = act_addr_q;
    act_data_d   = act_data_q;
    act_we_d     = act_we_q;
    resp_valid_d = resp_valid_q;
    resp_addr_d  = resp_addr_q;
    resp_value_d = resp_value_q;
    mem_we       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (deq) begin
          act_addr_d = q_addr_q[rd_ptr_q];
          act_data_d = q_data_q[rd_ptr_q];
          act_we_d   = q_we_q[rd_ptr_q];
          cnt_d      = LW'(LATENCY - 1);
          state_d    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (act_we_q) begin
          mem_we  = 1'b1;
          state_d = S_IDLE;
        end else begin
          resp_valid_d = 1'b1;
          resp_addr_d  = act_addr_q;
          resp_value_d = mem_q[act_idx];
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready_in) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      act_addr_q   <= '0;
      act_data_q   <= '0;
      act_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_value_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      act_addr_q   <= act_addr_d;
      act_data_q   <= act_data_d;
      act_we_q     <= act_we_d;
      resp_valid_q <= resp_valid_d;
      resp_addr_q  <= resp_addr_d;
      resp_value_q <= resp_value_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (enq) begin
      q_addr_q[wr_ptr_q] <= req_addr_in;
      q_data_q[wr_ptr_q] <= req_value_in;
      q_we_q[wr_ptr_q]   <= req_we_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (mem_we) mem_q[act_idx] <= act_data_q;
  end

endmodule
